// File: rtl/uart_pkg.sv
// uart_pkg - shared types and constants for the UART receive path.
//   rx_state_t       : receiver FSM states (kept apart from the transmitter's State)
//   BAUD_DIV_DEFAULT : clock cycles per bit at 100 MHz / 19200 baud
//   FRAME_BITS       : start + 8 data + parity + stop
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT = 5208;
  localparam int FRAME_BITS       = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BITS,
    PAR,
    STOP,
    ACK
  } rx_state_t;

endpackage

// File: rtl/rx_baud_timer.sv
// rx_baud_timer - bit-period timer for the UART receiver.
//   clk       : system clock
//   Reset_n   : asynchronous active-low reset
//   clrTimer  : forces the count back to 0
//   timerDone : high on the last count of a bit period (count wraps after it)
//   halfDone  : high at count HALF_DIV-1, used for the start-bit mid-sample
module rx_baud_timer #(
  parameter int BAUD_DIV = 5208,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clrTimer,
  output logic timerDone,
  output logic halfDone
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(HALF_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (clrTimer || timerDone) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign timerDone = (count == LAST);
  assign halfDone  = (count == HALF);

endmodule

// File: rtl/rx.sv
// rx - UART receiver: 1 start, 8 data (LSB first), odd parity, 1 stop.
// Samples each bit at mid-period and holds the byte until acknowledged.
//   clk        : system clock
//   Reset_n    : asynchronous active-low reset
//   Sin        : asynchronous serial line, idles high
//   ReceiveAck : host acknowledges the held byte
//   Dout       : last received data byte
//   Receive    : byte valid, held until ReceiveAck
//   parityErr  : odd-parity check failed for the byte in Dout
//   frameErr   : stop bit sampled 0 for the byte in Dout
//
// state | meaning
// IDLE  | line idle, timer held clear, waiting for a 1->0 edge
// START | timing to the start-bit mid-point, rejecting glitches
// BITS  | sampling the 8 data bits, one per bit period
// PAR   | sampling the parity bit
// STOP  | sampling the stop bit and capturing byte plus flags
// ACK   | Receive held high until the host acknowledges
module rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       Sin,
  input  logic       ReceiveAck,
  output logic [7:0] Dout,
  output logic       Receive,
  output logic       parityErr,
  output logic       frameErr
);

  rx_state_t cs, ns;

  logic       syncMeta, syncSin, histSin;
  logic       startEdge;
  logic       clrTimer, timerDone, halfDone;
  logic       clrBit, incBit, shiftEn, parEn, capture;
  logic [2:0] bitNum;
  logic [7:0] shiftReg;
  logic       parBit;

  // Synchronizer and history flops reset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      syncMeta <= 1'b1;
      syncSin  <= 1'b1;
      histSin  <= 1'b1;
    end else begin
      syncMeta <= Sin;
      syncSin  <= syncMeta;
      histSin  <= syncSin;
    end
  end

  // Edge rather than level, so a late ack mid-frame never starts on a low bit.
  assign startEdge = histSin & ~syncSin;

  rx_baud_timer #(
    .BAUD_DIV (BAUD_DIV),
    .HALF_DIV (HALF_DIV)
  ) uTimer (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .clrTimer  (clrTimer),
    .timerDone (timerDone),
    .halfDone  (halfDone)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cs <= IDLE;
    end else begin
      cs <= ns;
    end
  end

  always_comb begin
    ns       = cs;
    clrTimer = 1'b0;
    clrBit   = 1'b0;
    incBit   = 1'b0;
    shiftEn  = 1'b0;
    parEn    = 1'b0;
    capture  = 1'b0;
    Receive  = 1'b0;
    case (cs)
      IDLE: begin
        clrTimer = 1'b1;
        if (startEdge) ns = START;
      end
      START: begin
        if (halfDone) begin
          if (syncSin) begin
            ns = IDLE;
          end else begin
            ns       = BITS;
            clrTimer = 1'b1;
            clrBit   = 1'b1;
          end
        end
      end
      BITS: begin
        if (timerDone) begin
          shiftEn = 1'b1;
          if (bitNum == 3'd7) ns = PAR;
          else                incBit = 1'b1;
        end
      end
      PAR: begin
        if (timerDone) begin
          parEn = 1'b1;
          ns    = STOP;
        end
      end
      STOP: begin
        if (timerDone) begin
          capture = 1'b1;
          ns      = ACK;
        end
      end
      ACK: begin
        Receive = 1'b1;
        if (ReceiveAck) ns = IDLE;
      end
      default: ns = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bitNum   <= '0;
      shiftReg <= '0;
      parBit   <= 1'b0;
    end else begin
      if (clrBit)      bitNum <= '0;
      else if (incBit) bitNum <= bitNum + 3'd1;
      if (shiftEn) shiftReg[bitNum] <= syncSin;
      if (parEn)   parBit <= syncSin;
    end
  end

  // Total ones over data plus parity must be odd; flags hold until the next capture.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Dout      <= '0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
    end else if (capture) begin
      Dout      <= shiftReg;
      parityErr <= ~(^{shiftReg, parBit});
      frameErr  <= ~syncSin;
    end
  end

endmodule

// File: tb/tb_rx.sv
// tb_rx - self-checking bench for rx, driving Sin from a behavioural transmitter.
module tb_rx;

  localparam int BD = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       pErr;
    logic       fErr;
  } rxRec_t;

  logic       clk;
  logic       Reset_n;
  logic       Sin;
  logic       ReceiveAck;
  logic [7:0] Dout;
  logic       Receive;
  logic       parityErr;
  logic       frameErr;

  int checks = 0;
  int errors = 0;
  int rcvHigh = 0;
  logic prevRcv = 1'b0;

  rxRec_t rxQ[$];
  rxRec_t expQ[$];

  rx #(.BAUD_DIV(BD), .HALF_DIV(BD / 2)) dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .Sin        (Sin),
    .ReceiveAck (ReceiveAck),
    .Dout       (Dout),
    .Receive    (Receive),
    .parityErr  (parityErr),
    .frameErr   (frameErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every rising edge of Receive with the byte/flags shown at that time.
  always @(negedge clk) begin
    if (Receive && !prevRcv) rxQ.push_back({Dout, parityErr, frameErr});
    if (Receive) rcvHigh <= rcvHigh + 1;
    prevRcv <= Receive;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    Sin = 1'b1;
    repeat (n) tick();
  endtask

  task automatic sendBit(input logic b);
    Sin = b;
    repeat (BD) tick();
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic p, input logic stop);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
    sendBit(p);
    sendBit(stop);
  endtask

  function automatic logic goodPar(input logic [7:0] data);
    return ($countones(data) % 2) == 0;
  endfunction

  // Reference: parity error when data+parity holds an even number of ones.
  task automatic expectFrame(input logic [7:0] data, input logic p, input logic stop);
    rxRec_t r;
    r.data = data;
    r.pErr = ((($countones(data) + int'(p)) % 2) == 0);
    r.fErr = ~stop;
    expQ.push_back(r);
  endtask

  task automatic checkNext(input string tag);
    rxRec_t got, exp;
    int n;
    n = 0;
    while (rxQ.size() == 0 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(rxQ.size() > 0), 1);
    if (rxQ.size() > 0 && expQ.size() > 0) begin
      got = rxQ.pop_front();
      exp = expQ.pop_front();
      chk({tag, "_dout"}, 32'(got.data), 32'(exp.data));
      chk({tag, "_parityErr"}, 32'(got.pErr), 32'(exp.pErr));
      chk({tag, "_frameErr"}, 32'(got.fErr), 32'(exp.fErr));
    end
  endtask

  task automatic ackPulse(input string tag);
    chk({tag, "_held"}, 32'(Receive), 1);
    ReceiveAck = 1'b1;
    tick();
    ReceiveAck = 1'b0;
    chk({tag, "_released"}, 32'(Receive), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s;
    int         base;

    Reset_n    = 1'b0;
    Sin        = 1'b1;
    ReceiveAck = 1'b0;
    repeat (3) tick();
    chk("rst_dout", 32'(Dout), 0);
    chk("rst_receive", 32'(Receive), 0);
    chk("rst_parityErr", 32'(parityErr), 0);
    chk("rst_frameErr", 32'(frameErr), 0);
    Reset_n = 1'b1;
    idle(100);
    chk("idle_no_receive", 32'(rcvHigh), 0);

    expectFrame(8'hA5, 1'b1, 1'b1);
    sendFrame(8'hA5, 1'b1, 1'b1);
    checkNext("a5");
    ackPulse("a5_ack");
    idle(5);

    expectFrame(8'h00, 1'b0, 1'b1);
    sendFrame(8'h00, 1'b0, 1'b1);
    checkNext("00_badpar");
    ackPulse("00_ack");
    idle(5);

    expectFrame(8'h3C, 1'b1, 1'b0);
    sendFrame(8'h3C, 1'b1, 1'b0);
    idle(2);
    checkNext("3c_badstop");
    ackPulse("3c_ack");
    idle(5);

    Sin = 1'b0;
    repeat (4) tick();
    idle(40);
    chk("glitch_no_receive", 32'(rxQ.size()), 0);
    expectFrame(8'h5A, goodPar(8'h5A), 1'b1);
    sendFrame(8'h5A, goodPar(8'h5A), 1'b1);
    checkNext("5a_after_glitch");
    ackPulse("5a_ack");
    idle(5);

    ReceiveAck = 1'b1;
    base = rcvHigh;
    expectFrame(8'h12, goodPar(8'h12), 1'b1);
    expectFrame(8'h34, goodPar(8'h34), 1'b1);
    sendFrame(8'h12, goodPar(8'h12), 1'b1);
    sendFrame(8'h34, goodPar(8'h34), 1'b1);
    idle(10);
    chk("b2b_pulse_cycles", 32'(rcvHigh - base), 2);
    checkNext("b2b_12");
    checkNext("b2b_34");
    ReceiveAck = 1'b0;
    idle(5);

    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0) ? ~goodPar(d) : goodPar(d);
      s = ($urandom_range(0, 3) != 0);
      expectFrame(d, p, s);
      sendFrame(d, p, s);
      idle(2);
      checkNext($sformatf("rand%0d", k));
      ackPulse($sformatf("rand%0d_ack", k));
      idle(5);
    end

    expectFrame(8'hC3, goodPar(8'hC3), 1'b1);
    sendFrame(8'hC3, goodPar(8'hC3), 1'b1);
    checkNext("held_c3");
    sendFrame(8'h7E, goodPar(8'h7E), 1'b1);
    idle(5);
    chk("lost_no_new_rx", 32'(rxQ.size()), 0);
    chk("lost_dout_kept", 32'(Dout), 32'h0C3);
    ackPulse("held_ack");
    idle(5);

    base = rcvHigh;
    Sin = 1'b0;
    repeat (BD * 4) tick();
    Reset_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(Dout), 0);
    chk("midrst_receive", 32'(Receive), 0);
    chk("midrst_parityErr", 32'(parityErr), 0);
    chk("midrst_frameErr", 32'(frameErr), 0);
    Sin = 1'b1;
    repeat (2) tick();
    Reset_n = 1'b1;
    idle(BD * 10);
    chk("midrst_no_receive", 32'(rcvHigh - base), 0);
    expectFrame(8'hFF, 1'b1, 1'b1);
    sendFrame(8'hFF, 1'b1, 1'b1);
    checkNext("ff_after_rst");
    ackPulse("ff_ack");
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
